affine_ub_multiport: RTL and testbench
======================================

// Module: affine_ub_multiport
// PURPOSE
//  Parametrised unified buffer with internal affine address generators: one write port, NUM_RD read ports.
//  - Each port walks its own NUM_DIMS loop nest with counters held inside the block, so callers no longer drive ctrl_vars.
//  - Generalises the fixed 64x64 / 1-read UB and the fixed 2-deep delay SR: runtime extents/strides, N readers,
//    registered reads with optional extra delay, done/error reporting.
//  - Sits between a producer hcompute op and NUM_RD consumer ops in generated stencil pipelines.
// PARAMETERS
//  DATA_W     16    data word width
//  NUM_DIMS   3     loop-nest depth per port (dim 0 innermost)
//  CTR_W      16    loop counter / extent / stride width
//  CAPACITY   4096  storage words; ADDR_W = $clog2(CAPACITY)
//  NUM_RD     2     number of read ports
//  RD_DELAY   0     extra pipeline stages on read data (total read latency 1+RD_DELAY)
// PORTS
//  clk        in   1                     clock
//  rst_n      in   1                     async active-low reset
//  flush      in   1                     sync restart of all counters/flags; storage kept
//  wr_en      in   1                     write current data, advance write nest
//  wr_data    in   DATA_W                write data
//  wr_extent  in   NUM_DIMS*CTR_W        write trip counts, quasi-static
//  wr_stride  in   NUM_DIMS*CTR_W        write strides (unsigned)
//  wr_offset  in   32                    write base address
//  rd_en      in   NUM_RD                per-port read request, advances that port's nest
//  rd_extent  in   NUM_RD*NUM_DIMS*CTR_W per-port read trip counts
//  rd_stride  in   NUM_RD*NUM_DIMS*CTR_W per-port read strides
//  rd_offset  in   NUM_RD*32             per-port read base
//  rd_data    out  NUM_RD*DATA_W         read data
//  rd_valid   out  NUM_RD                rd_data valid for that port
//  wr_done    out  1                     sticky: write nest completed
//  rd_done    out  NUM_RD                sticky: read nest k completed
//  err        out  1                     sticky: out-of-range or post-done access
// BEHAVIOUR
//  - Reset (async): all counters 0; rd_data, rd_valid, wr_done, rd_done, err = 0. RAM contents undefined.
//  - flush: same clear as reset, taken at clk edge; beats coinciding with flush are dropped.
//  - Address: 32-bit unsigned sum offset + sum_i(stride_i*ctr_i). In range iff < CAPACITY.
//  - Counter step on enabled beat:
//    - ctr0 increments.
//    - ctr_i wraps to 0 and carries into ctr_{i+1} when ctr_i == extent_i-1.
//    - extent 0 is treated as 1.
//  - Last beat (all ctr_i == extent_i-1): counters wrap to 0 and done is set the next cycle.
//  - Any beat with done=1 does not write and returns no valid data; it sets err.
//  - Write: RAM[addr] <= wr_data at edge if wr_en, in range, and !wr_done.
//    Out of range: no write, err=1, counters still advance.
//  - Read: data is registered. rd_data[k] and rd_valid[k] appear 1+RD_DELAY cycles after rd_en[k].
//    Out-of-range read: rd_valid still pulses, rd_data=0, err=1.
//    rd_valid is low in cycles with no request.
//  - Same-cycle write and read of one address: read returns old data (read-before-write).
//  - Readers are independent. Any number of them may hit the same address in one cycle.
//  - No back-pressure. Caller schedule guarantees write-before-read ordering; the block does not check hazards.
//  - Config changes are allowed only while all ports are idle, or right after flush.
// STRUCTURE
//  - Package affine_ub_pkg:
//    - typedef ctr_t (CTR_W)
//    - typedef addr32_t
//    - function affine_addr(offset, strides, ctrs)
//    - localparam default sizes
//  - Sub-module affine_addr_gen: the loop-nest counter, address sum and done flag.
//    - Instantiated 1 + NUM_RD times.
//    - Outputs addr, in_range and last.
//  - Top level holds the RAM array, the write port, the per-port read registers and the RD_DELAY shift pipes.
// TESTING
//  1. Raster: extents {64,64,1}, strides {1,64,0}. Write 4096 ramp values, then read port 0 raster
//     -> data == ramp, latency 1, wr_done and rd_done[0] set after the last beat.
//  2. Two readers, same nest, port 1 offset 1
//     -> port 1 data equals port 0 data shifted by one word. Simultaneous reads are correct.
//  3. Read and write RAM[5] in the same cycle, old=0xAAAA, new=0x5555
//     -> rd_data=0xAAAA. The next read returns 0x5555.
//  4. wr_offset=4095, stride0=1, 2 beats
//     -> first beat writes, second beat sets err with no write. A read of the err address gives rd_valid=1, rd_data=0.
//  5. Mid-nest flush and async reset, asserted after 10 beats
//     -> counters 0, flags 0. The next beat writes offset and RAM data survives flush.
//  6. RD_DELAY=3, extent 0 on dim 2
//     -> read latency 4. Extent 0 behaves as 1: the nest ends after ext0*ext1 beats.

Source files
------------

// File: rtl/affine_ub_pkg.sv
// Shared types, default sizes and address helper for the affine unified buffer.
package affine_ub_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_NUM_DIMS = 3;
    localparam int unsigned DEF_CTR_W    = 16;
    localparam int unsigned DEF_CAPACITY = 4096;
    localparam int unsigned DEF_NUM_RD   = 2;
    localparam int unsigned DEF_RD_DELAY = 0;

    typedef logic [DEF_CTR_W-1:0] ctr_t;
    typedef logic [31:0]          addr32_t;

    function automatic addr32_t affine_addr(
        input addr32_t                               offset,
        input logic [DEF_NUM_DIMS*DEF_CTR_W-1:0]     strides,
        input logic [DEF_NUM_DIMS*DEF_CTR_W-1:0]     ctrs
    );
        addr32_t sum;
        sum = offset;
        for (int unsigned i = 0; i < DEF_NUM_DIMS; i++) begin
            sum = sum + addr32_t'(strides[i*DEF_CTR_W +: DEF_CTR_W])
                      * addr32_t'(ctrs[i*DEF_CTR_W +: DEF_CTR_W]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/affine_ub_multiport_addr_gen.sv
// Loop-nest counter with affine address sum; one instance per buffer port.
module affine_addr_gen
    import affine_ub_pkg::*;
#(
    parameter int unsigned NUM_DIMS = DEF_NUM_DIMS,
    parameter int unsigned CTR_W    = DEF_CTR_W,
    parameter int unsigned CAPACITY = DEF_CAPACITY,
    parameter int unsigned ADDR_W   = $clog2(CAPACITY)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      step,
    input  logic [NUM_DIMS*CTR_W-1:0] extent,
    input  logic [NUM_DIMS*CTR_W-1:0] stride,
    input  logic [31:0]               offset,
    output logic [ADDR_W-1:0]         addr,
    output logic                      in_range,
    output logic                      last
);

    logic [CTR_W-1:0] ctr     [NUM_DIMS];
    logic [CTR_W-1:0] ctr_nxt [NUM_DIMS];
    logic [CTR_W-1:0] ext_m1  [NUM_DIMS];
    addr32_t          sum;
    logic             carry;

    // An extent of 0 runs the dimension once, same as 1.
    always_comb begin
        for (int unsigned i = 0; i < NUM_DIMS; i++) begin
            if (extent[i*CTR_W +: CTR_W] == '0) ext_m1[i] = '0;
            else                                ext_m1[i] = extent[i*CTR_W +: CTR_W] - 1'b1;
        end
    end

    always_comb begin
        sum   = offset;
        last  = 1'b1;
        carry = 1'b1;
        for (int unsigned i = 0; i < NUM_DIMS; i++) begin
            sum        = sum + addr32_t'(stride[i*CTR_W +: CTR_W]) * addr32_t'(ctr[i]);
            ctr_nxt[i] = ctr[i];
            if (ctr[i] != ext_m1[i]) last = 1'b0;
            if (carry) begin
                if (ctr[i] == ext_m1[i]) begin
                    ctr_nxt[i] = '0;
                end else begin
                    ctr_nxt[i] = ctr[i] + 1'b1;
                    carry      = 1'b0;
                end
            end
        end
        in_range = (sum < addr32_t'(CAPACITY));
        addr     = sum[ADDR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_DIMS; i++) ctr[i] <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < NUM_DIMS; i++) ctr[i] <= '0;
        end else if (step) begin
            ctr <= ctr_nxt;
        end
    end

endmodule

// File: rtl/affine_ub_multiport.sv
// Unified buffer with one affine write port and NUM_RD affine read ports.
module affine_ub_multiport
    import affine_ub_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_DIMS = DEF_NUM_DIMS,
    parameter int unsigned CTR_W    = DEF_CTR_W,
    parameter int unsigned CAPACITY = DEF_CAPACITY,
    parameter int unsigned NUM_RD   = DEF_NUM_RD,
    parameter int unsigned RD_DELAY = DEF_RD_DELAY
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             wr_en,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic [NUM_DIMS*CTR_W-1:0]        wr_extent,
    input  logic [NUM_DIMS*CTR_W-1:0]        wr_stride,
    input  logic [31:0]                      wr_offset,
    input  logic [NUM_RD-1:0]                rd_en,
    input  logic [NUM_RD*NUM_DIMS*CTR_W-1:0] rd_extent,
    input  logic [NUM_RD*NUM_DIMS*CTR_W-1:0] rd_stride,
    input  logic [NUM_RD*32-1:0]             rd_offset,
    output logic [NUM_RD*DATA_W-1:0]         rd_data,
    output logic [NUM_RD-1:0]                rd_valid,
    output logic                             wr_done,
    output logic [NUM_RD-1:0]                rd_done,
    output logic                             err
);

    localparam int unsigned ADDR_W = $clog2(CAPACITY);
    localparam int unsigned NEST_W = NUM_DIMS*CTR_W;

    logic [DATA_W-1:0] mem [CAPACITY];

    logic [ADDR_W-1:0] wr_addr;
    logic              wr_in_range, wr_last, wr_beat, wr_step;
    logic [ADDR_W-1:0] rd_addr [NUM_RD];
    logic [NUM_RD-1:0] rd_in_range, rd_last, rd_beat, rd_bad;

    // Beats coinciding with flush are dropped; beats after done only flag err.
    assign wr_beat = wr_en && !flush;
    assign wr_step = wr_beat && !wr_done;

    affine_addr_gen #(.NUM_DIMS(NUM_DIMS), .CTR_W(CTR_W), .CAPACITY(CAPACITY), .ADDR_W(ADDR_W)) u_wr_gen (
        .clk(clk), .rst_n(rst_n), .flush(flush), .step(wr_step),
        .extent(wr_extent), .stride(wr_stride), .offset(wr_offset),
        .addr(wr_addr), .in_range(wr_in_range), .last(wr_last)
    );

    always_ff @(posedge clk) begin
        if (wr_step && wr_in_range) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_done <= 1'b0;
            err     <= 1'b0;
        end else if (flush) begin
            wr_done <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (wr_step && wr_last) wr_done <= 1'b1;
            if ((wr_beat && (wr_done || !wr_in_range)) || (|rd_bad)) err <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [DATA_W-1:0] pipe_data [RD_DELAY+1];
        logic [RD_DELAY:0] pipe_valid;
        logic              done_q;

        assign rd_beat[k] = rd_en[k] && !flush && !done_q;
        assign rd_bad[k]  = rd_en[k] && !flush && (done_q || !rd_in_range[k]);

        affine_addr_gen #(.NUM_DIMS(NUM_DIMS), .CTR_W(CTR_W), .CAPACITY(CAPACITY), .ADDR_W(ADDR_W)) u_rd_gen (
            .clk(clk), .rst_n(rst_n), .flush(flush), .step(rd_beat[k]),
            .extent(rd_extent[k*NEST_W +: NEST_W]), .stride(rd_stride[k*NEST_W +: NEST_W]),
            .offset(rd_offset[k*32 +: 32]),
            .addr(rd_addr[k]), .in_range(rd_in_range[k]), .last(rd_last[k])
        );

        // Stage 0 samples the RAM before this edge's write lands (read-before-write).
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                done_q     <= 1'b0;
                pipe_valid <= '0;
                for (int unsigned i = 0; i <= RD_DELAY; i++) pipe_data[i] <= '0;
            end else if (flush) begin
                done_q     <= 1'b0;
                pipe_valid <= '0;
                for (int unsigned i = 0; i <= RD_DELAY; i++) pipe_data[i] <= '0;
            end else begin
                if (rd_beat[k] && rd_last[k]) done_q <= 1'b1;
                pipe_valid[0] <= rd_beat[k];
                pipe_data[0]  <= (rd_beat[k] && rd_in_range[k]) ? mem[rd_addr[k]] : '0;
                for (int unsigned i = 1; i <= RD_DELAY; i++) begin
                    pipe_valid[i] <= pipe_valid[i-1];
                    pipe_data[i]  <= pipe_data[i-1];
                end
            end
        end

        assign rd_done[k]                   = done_q;
        assign rd_valid[k]                  = pipe_valid[RD_DELAY];
        assign rd_data[k*DATA_W +: DATA_W]  = pipe_data[RD_DELAY];
    end

endmodule

// File: tb/tb_affine_ub_multiport.sv
// Directed bench for affine_ub_multiport: nest-level model plus literal pins.
module tb_affine_ub_multiport;

    localparam int DW  = 16;
    localparam int ND  = 3;
    localparam int CW  = 16;
    localparam int CAP = 4096;
    localparam int NR  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- main DUT (default parameters) ----------------
    logic               flush = 1'b0;
    logic               wr_en = 1'b0;
    logic [DW-1:0]      wr_data = '0;
    logic [NR-1:0]      rd_en = '0;
    logic [ND*CW-1:0]   wr_extent, wr_stride;
    logic [31:0]        wr_offset;
    logic [NR*ND*CW-1:0] rd_extent, rd_stride;
    logic [NR*32-1:0]   rd_offset;
    logic [NR*DW-1:0]   rd_data;
    logic [NR-1:0]      rd_valid, rd_done;
    logic               wr_done, err;

    int unsigned wext[3], wstr[3], woff;
    int unsigned rext[NR][3], rstr[NR][3], roff[NR];

    always_comb begin
        wr_extent = '0;
        wr_stride = '0;
        rd_extent = '0;
        rd_stride = '0;
        rd_offset = '0;
        wr_offset = woff;
        for (int d = 0; d < ND; d++) begin
            wr_extent[d*CW +: CW] = CW'(wext[d]);
            wr_stride[d*CW +: CW] = CW'(wstr[d]);
        end
        for (int k = 0; k < NR; k++) begin
            rd_offset[k*32 +: 32] = roff[k];
            for (int d = 0; d < ND; d++) begin
                rd_extent[(k*ND+d)*CW +: CW] = CW'(rext[k][d]);
                rd_stride[(k*ND+d)*CW +: CW] = CW'(rstr[k][d]);
            end
        end
    end

    affine_ub_multiport #(.DATA_W(DW), .NUM_DIMS(ND), .CTR_W(CW), .CAPACITY(CAP),
                          .NUM_RD(NR), .RD_DELAY(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data),
        .wr_extent(wr_extent), .wr_stride(wr_stride), .wr_offset(wr_offset),
        .rd_en(rd_en), .rd_extent(rd_extent), .rd_stride(rd_stride), .rd_offset(rd_offset),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_done(wr_done), .rd_done(rd_done), .err(err)
    );

    // ---------------- second DUT: RD_DELAY=3, small RAM ----------------
    logic          w2_en = 1'b0;
    logic [DW-1:0] w2_data = '0;
    logic [0:0]    r2_en = 1'b0;
    logic [DW-1:0] r2_data;
    logic [0:0]    r2_valid, r2_done;
    logic          w2_done, err2;
    logic [ND*CW-1:0] nest2_ext = {16'd0, 16'd2, 16'd4};
    logic [ND*CW-1:0] nest2_str = {16'd0, 16'd4, 16'd1};

    affine_ub_multiport #(.DATA_W(DW), .NUM_DIMS(ND), .CTR_W(CW), .CAPACITY(64),
                          .NUM_RD(1), .RD_DELAY(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .wr_en(w2_en), .wr_data(w2_data),
        .wr_extent(nest2_ext), .wr_stride(nest2_str), .wr_offset(32'd0),
        .rd_en(r2_en), .rd_extent(nest2_ext), .rd_stride(nest2_str), .rd_offset(32'd0),
        .rd_data(r2_data), .rd_valid(r2_valid),
        .wr_done(w2_done), .rd_done(r2_done), .err(err2)
    );

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned mx(input int unsigned e);
        return (e == 0) ? 1 : e;
    endfunction

    // Address of beat n: decompose n into loop indices, then weight by strides.
    function automatic logic [31:0] nest_addr(input int unsigned off, input int unsigned e0,
            input int unsigned e1, input int unsigned s0, input int unsigned s1,
            input int unsigned s2, input int unsigned n);
        int unsigned c0, c1, c2;
        c0 = n % mx(e0);
        c1 = (n / mx(e0)) % mx(e1);
        c2 = n / (mx(e0) * mx(e1));
        return off + s0*c0 + s1*c1 + s2*c2;
    endfunction

    // ---------------- behavioural model of the main DUT ----------------
    logic [DW-1:0] mmem [CAP];
    int unsigned   wn, rn[NR];
    bit            mwdone, merr;
    bit            mrdone[NR];
    bit            mv[NR];
    logic [DW-1:0] md[NR];

    task automatic model_clear();
        wn = 0; mwdone = 0; merr = 0;
        for (int k = 0; k < NR; k++) begin
            rn[k] = 0; mrdone[k] = 0; mv[k] = 0; md[k] = '0;
        end
    endtask

    task automatic model_step();
        logic [31:0] a;
        if (!rst_n || flush) begin
            model_clear();
        end else begin
            for (int k = 0; k < NR; k++) begin
                mv[k] = 0;
                if (rd_en[k]) begin
                    if (mrdone[k]) begin
                        merr = 1;
                    end else begin
                        a = nest_addr(roff[k], rext[k][0], rext[k][1],
                                      rstr[k][0], rstr[k][1], rstr[k][2], rn[k]);
                        mv[k] = 1;
                        if (a < CAP) md[k] = mmem[a[11:0]];
                        else begin md[k] = '0; merr = 1; end
                        rn[k]++;
                        if (rn[k] == mx(rext[k][0])*mx(rext[k][1])*mx(rext[k][2])) begin
                            rn[k] = 0; mrdone[k] = 1;
                        end
                    end
                end
            end
            if (wr_en) begin
                if (mwdone) begin
                    merr = 1;
                end else begin
                    a = nest_addr(woff, wext[0], wext[1], wstr[0], wstr[1], wstr[2], wn);
                    if (a < CAP) mmem[a[11:0]] = wr_data;
                    else merr = 1;
                    wn++;
                    if (wn == mx(wext[0])*mx(wext[1])*mx(wext[2])) begin
                        wn = 0; mwdone = 1;
                    end
                end
            end
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NR; k++) begin
                chk($sformatf("rd_valid[%0d]", k), 32'(rd_valid[k]), 32'(mv[k]));
                if (mv[k]) chk($sformatf("rd_data[%0d]", k), 32'(rd_data[k*DW +: DW]), 32'(md[k]));
                chk($sformatf("rd_done[%0d]", k), 32'(rd_done[k]), 32'(mrdone[k]));
            end
            chk("wr_done", 32'(wr_done), 32'(mwdone));
            chk("err", 32'(err), 32'(merr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic set_nest(output int unsigned e[3], output int unsigned s[3],
            input int unsigned e0, input int unsigned e1, input int unsigned e2,
            input int unsigned s0, input int unsigned s1, input int unsigned s2);
        e[0] = e0; e[1] = e1; e[2] = e2;
        s[0] = s0; s[1] = s1; s[2] = s2;
    endtask

    initial begin
        #1_000_000;
        chk("watchdog", 32'd1, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        set_nest(wext, wstr, 64, 64, 1, 1, 64, 0);
        woff = 0;
        for (int k = 0; k < NR; k++) begin
            set_nest(rext[k], rstr[k], 64, 64, 1, 1, 64, 0);
            roff[k] = 0;
        end
        repeat (2) @(negedge clk);
        chk("reset_wr_done", 32'(wr_done), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        do_flush();

        // Raster write then raster read on port 0.
        for (int i = 0; i < 4096; i++) begin
            wr_en = 1'b1; wr_data = 16'(32'h100 + i);
            @(negedge clk);
            if (i == 4094) chk("wr_done_before_last", 32'(wr_done), 32'd0);
        end
        wr_en = 1'b0;
        chk("wr_done_raster", 32'(wr_done), 32'd1);
        for (int i = 0; i < 4096; i++) begin
            rd_en = 2'b01;
            @(negedge clk);
            if (i == 0) begin
                chk("lat1_valid", 32'(rd_valid[0]), 32'd1);
                chk("lat1_data", 32'(rd_data[15:0]), 32'h0100);
            end
            if (i == 4095) chk("raster_last_data", 32'(rd_data[15:0]), 32'h10FF);
        end
        rd_en = '0;
        chk("rd_done0_raster", 32'(rd_done[0]), 32'd1);
        @(negedge clk);
        chk("rd_valid_idle", 32'(rd_valid), 32'd0);

        // Two readers, port 1 one word ahead.
        roff[1] = 1;
        do_flush();
        for (int i = 0; i < 200; i++) begin
            rd_en = 2'b11;
            @(negedge clk);
            if (i == 3) begin
                chk("dual_p0", 32'(rd_data[15:0]), 32'h0103);
                chk("dual_p1", 32'(rd_data[31:16]), 32'h0104);
            end
        end
        rd_en = '0;

        // Same-cycle read and write of address 5.
        set_nest(wext, wstr, 1, 1, 1, 0, 0, 0);
        woff = 5;
        do_flush();
        wr_en = 1'b1; wr_data = 16'hAAAA;
        @(negedge clk);
        wr_en = 1'b0;
        set_nest(rext[0], rstr[0], 2, 1, 1, 0, 0, 0);
        roff[0] = 5;
        do_flush();
        wr_en = 1'b1; wr_data = 16'h5555; rd_en = 2'b01;
        @(negedge clk);
        wr_en = 1'b0; rd_en = '0;
        chk("rbw_old", 32'(rd_data[15:0]), 32'hAAAA);
        rd_en = 2'b01;
        @(negedge clk);
        rd_en = '0;
        chk("rbw_new", 32'(rd_data[15:0]), 32'h5555);

        // Top-of-memory boundary.
        set_nest(wext, wstr, 2, 1, 1, 1, 0, 0);
        woff = 4095;
        set_nest(rext[0], rstr[0], 2, 1, 1, 1, 0, 0);
        roff[0] = 4095;
        do_flush();
        chk("bound_err_clear", 32'(err), 32'd0);
        wr_en = 1'b1; wr_data = 16'h1234;
        @(negedge clk);
        chk("bound_first_ok", 32'(err), 32'd0);
        wr_data = 16'h4321;
        @(negedge clk);
        wr_en = 1'b0;
        chk("bound_second_err", 32'(err), 32'd1);
        rd_en = 2'b01;
        @(negedge clk);
        chk("bound_rd_4095", 32'(rd_data[15:0]), 32'h1234);
        @(negedge clk);
        rd_en = '0;
        chk("bound_oor_valid", 32'(rd_valid[0]), 32'd1);
        chk("bound_oor_data", 32'(rd_data[15:0]), 32'h0000);

        // Mid-nest flush: storage survives, counters restart.
        set_nest(wext, wstr, 64, 64, 1, 1, 64, 0);
        woff = 100;
        do_flush();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_data = 16'(32'h7000 + i);
            @(negedge clk);
        end
        flush = 1'b1; wr_data = 16'hDEAD;
        @(negedge clk);
        flush = 1'b0; wr_en = 1'b0;
        chk("flush_err", 32'(err), 32'd0);
        chk("flush_wr_done", 32'(wr_done), 32'd0);
        wr_en = 1'b1; wr_data = 16'h0BAD;
        @(negedge clk);
        wr_en = 1'b0;
        set_nest(rext[0], rstr[0], 11, 1, 1, 1, 0, 0);
        roff[0] = 100;
        for (int i = 0; i < 11; i++) begin
            rd_en = 2'b01;
            @(negedge clk);
            if (i == 0) chk("flush_restart", 32'(rd_data[15:0]), 32'h0BAD);
            if (i == 1) chk("flush_kept", 32'(rd_data[15:0]), 32'h7001);
        end
        rd_en = '0;

        // Mid-nest async reset.
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_data = 16'(32'h6000 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_done", 32'(wr_done), 32'd0);
        chk("arst_rd_done", 32'(rd_done), 32'd0);
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b1; wr_data = 16'h0FED;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 2'b01;
        @(negedge clk);
        chk("arst_restart", 32'(rd_data[15:0]), 32'h0FED);
        @(negedge clk);
        rd_en = '0;
        chk("arst_kept", 32'(rd_data[15:0]), 32'h6000);

        // RD_DELAY=3 instance, extent 0 on dim 2 acts as 1 (8-beat nest).
        for (int i = 0; i < 8; i++) begin
            w2_en = 1'b1; w2_data = 16'(32'h20 + i);
            @(negedge clk);
            if (i == 6) chk("d3_wr_done_early", 32'(w2_done), 32'd0);
        end
        w2_en = 1'b0;
        chk("d3_wr_done", 32'(w2_done), 32'd1);
        r2_en = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            r2_en = 1'b0;
            n++;
            if (r2_valid[0]) break;
        end
        chk("d3_latency", 32'(n), 32'd4);
        chk("d3_first_data", 32'(r2_data), 32'h0020);
        for (int i = 0; i < 7; i++) begin
            r2_en = 1'b1;
            @(negedge clk);
            if (i == 5) chk("d3_rd_done_early", 32'(r2_done), 32'd0);
        end
        chk("d3_rd_done", 32'(r2_done), 32'd1);
        chk("d3_err_before", 32'(err2), 32'd0);
        @(negedge clk);
        r2_en = 1'b0;
        chk("d3_err_post_done", 32'(err2), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("d3_last_valid", 32'(r2_valid), 32'd1);
        chk("d3_last_data", 32'(r2_data), 32'h0027);
        @(negedge clk);
        chk("d3_post_done_novalid", 32'(r2_valid), 32'd0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
